// File: rtl/fabric_frame_loader.sv
// rtl/fabric_frame_loader.sv - assembles bitstream words into fabric frames and fires one-hot frame strobes
module fabric_frame_loader #(
  parameter int          NUM_COLUMNS       = 10,
  parameter int          NUM_ROWS          = 12,
  parameter int          FRAMES_PER_COLUMN = 20,
  parameter logic [31:0] SYNC_WORD         = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD       = 32'hDE5E_C0DE
) (
  input  logic                                    clk_i,
  input  logic                                    rst_ni,
  input  logic [31:0]                             word_i,
  input  logic                                    word_valid_i,
  input  logic                                    clear_i,
  output logic [32*NUM_ROWS-1:0]                  frame_data_o,
  output logic [NUM_COLUMNS*FRAMES_PER_COLUMN-1:0] frame_strobe_o,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic                                    error_o
);

  localparam int SW = NUM_COLUMNS * FRAMES_PER_COLUMN;
  localparam int RW = $clog2(NUM_ROWS + 1);

  typedef enum logic [1:0] {S_SYNC, S_ADDR, S_DATA, S_STROBE} state_t;

  state_t        state;
  logic [7:0]    col_q;
  logic [7:0]    frm_q;
  logic [RW-1:0] row_q;
  logic          addr_ok_q;
  logic          addr_in_range;
  logic [31:0]   strobe_idx;
  logic [SW-1:0] strobe_onehot;

  assign addr_in_range = (32'(word_i[31:24]) < 32'(NUM_COLUMNS)) &&
                         (32'(word_i[23:16]) < 32'(FRAMES_PER_COLUMN));
  assign strobe_idx    = 32'(col_q) * 32'(FRAMES_PER_COLUMN) + 32'(frm_q);
  // An out-of-range frame is still consumed, it just never reaches the strobe lines.
  assign strobe_onehot = addr_ok_q ? (SW'(1) << strobe_idx) : '0;
  assign busy_o        = (state != S_SYNC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= S_SYNC;
      col_q          <= '0;
      frm_q          <= '0;
      row_q          <= '0;
      addr_ok_q      <= 1'b0;
      frame_data_o   <= '0;
      frame_strobe_o <= '0;
      done_o         <= 1'b0;
      error_o        <= 1'b0;
    end else begin
      frame_strobe_o <= '0;
      done_o         <= 1'b0;
      if (clear_i) begin
        state   <= S_SYNC;
        error_o <= 1'b0;
        row_q   <= '0;
      end else begin
        case (state)
          S_SYNC: begin
            if (word_valid_i && word_i == SYNC_WORD) state <= S_ADDR;
          end
          S_ADDR: begin
            if (word_valid_i) begin
              if (word_i == DESYNC_WORD) begin
                done_o <= 1'b1;
                state  <= S_SYNC;
              end else begin
                col_q     <= word_i[31:24];
                frm_q     <= word_i[23:16];
                row_q     <= '0;
                addr_ok_q <= addr_in_range;
                if (!addr_in_range) error_o <= 1'b1;
                state     <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (word_valid_i) begin
              // First word of a frame lands in the most significant slice.
              for (int r = 0; r < NUM_ROWS; r++) begin
                if (row_q == RW'(r)) frame_data_o[32*(NUM_ROWS-r)-1 -: 32] <= word_i;
              end
              if (row_q == RW'(NUM_ROWS - 1)) begin
                row_q          <= '0;
                frame_strobe_o <= strobe_onehot;
                state          <= S_STROBE;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end
          end
          S_STROBE: begin
            if (word_valid_i) error_o <= 1'b1;
            state <= S_ADDR;
          end
          default: state <= S_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fabric_frame_loader.sv
// tb/tb_fabric_frame_loader.sv - scoreboard bench for fabric_frame_loader
module tb_fabric_frame_loader;

  localparam int NC = 3;
  localparam int NR = 2;
  localparam int FPC = 4;
  localparam int SW = NC * FPC;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC = 32'hDE5E_C0DE;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic [31:0]       word_i = '0;
  logic              word_valid_i = 1'b0;
  logic              clear_i = 1'b0;
  logic [32*NR-1:0]  frame_data_o;
  logic [SW-1:0]     frame_strobe_o;
  logic              busy_o, done_o, error_o;

  fabric_frame_loader #(
    .NUM_COLUMNS(NC), .NUM_ROWS(NR), .FRAMES_PER_COLUMN(FPC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .word_i(word_i), .word_valid_i(word_valid_i),
    .clear_i(clear_i), .frame_data_o(frame_data_o), .frame_strobe_o(frame_strobe_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int done_exp = 0;

  typedef struct packed {
    logic [SW-1:0]    strobe;
    logic [32*NR-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni && done_o) done_cnt++;
    if (rst_ni && frame_strobe_o != '0) begin
      check("strobe_onehot", 64'($countones(frame_strobe_o)), 64'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(frame_strobe_o), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_bits", 64'(frame_strobe_o), 64'(e.strobe));
        check("strobe_data", 64'(frame_data_o), 64'(e.data));
      end
    end
  end

  task automatic send(input logic [31:0] w, input int gap);
    @(negedge clk_i);
    word_i = w;
    word_valid_i = 1'b1;
    @(negedge clk_i);
    word_valid_i = 1'b0;
    repeat (gap) @(negedge clk_i);
  endtask

  task automatic expect_strobe(input int bit_idx, input logic [31:0] d0, input logic [31:0] d1);
    exp_t e;
    e.strobe = SW'(1) << bit_idx;
    e.data   = {d0, d1};
    exp_q.push_back(e);
  endtask

  task automatic frame(input int col, input int frm, input logic [31:0] d0, input logic [31:0] d1);
    send({8'(col), 8'(frm), 16'h0}, 2);
    send(d0, 2);
    expect_strobe(col * FPC + frm, d0, d1);
    send(d1, 2);
  endtask

  task automatic pulse_clear();
    @(negedge clk_i);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_data", 64'(frame_data_o), 64'd0);
    check("rst_strobe", 64'(frame_strobe_o), 64'd0);
    check("rst_flags", {61'd0, busy_o, done_o, error_o}, 64'd0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk_i);

    // normal frame
    send(SYNC, 2);
    check("busy_after_sync", 64'(busy_o), 64'd1);
    frame(1, 2, 32'hAAAA_AAAA, 32'h5555_5555);
    send(DESYNC, 2); done_exp++;
    check("normal_data", 64'(frame_data_o), 64'hAAAA_AAAA_5555_5555);
    check("normal_busy", 64'(busy_o), 64'd0);
    check("normal_done", 64'(done_cnt), 64'(done_exp));

    // pre-sync garbage
    send(32'h1234_5678, 2);
    send(32'h0, 2);
    check("garbage_busy", 64'(busy_o), 64'd0);
    send(SYNC, 2);
    frame(2, 1, 32'h0BAD_F00D, 32'hC0FF_EE00);
    send(DESYNC, 2); done_exp++;
    check("garbage_error", 64'(error_o), 64'd0);

    // invalid address, then a valid frame; SYNC as data is plain content
    send(SYNC, 2);
    send(32'h0300_0000, 2);
    send(32'h1111_1111, 2);
    send(SYNC, 2);
    check("invalid_error", 64'(error_o), 64'd1);
    check("invalid_data", 64'(frame_data_o), {32'h1111_1111, SYNC});
    frame(0, 3, 32'h2222_2222, 32'h3333_3333);
    send(DESYNC, 2); done_exp++;
    check("invalid_error_sticky", 64'(error_o), 64'd1);
    pulse_clear();
    check("clear_error", 64'(error_o), 64'd0);

    // back-to-back words, next address overruns the strobe cycle
    @(negedge clk_i);
    word_valid_i = 1'b1;
    word_i = SYNC;          @(negedge clk_i);
    word_i = 32'h0000_0000; @(negedge clk_i);
    expect_strobe(0, 32'h4444_4444, 32'h7777_7777);
    word_i = 32'h4444_4444; @(negedge clk_i);
    word_i = 32'h7777_7777; @(negedge clk_i);
    word_i = 32'h0101_0000; @(negedge clk_i);
    word_valid_i = 1'b0;
    @(negedge clk_i);
    check("overrun_error", 64'(error_o), 64'd1);
    check("overrun_busy", 64'(busy_o), 64'd1);
    send(DESYNC, 2); done_exp++;
    check("overrun_done", 64'(done_cnt), 64'(done_exp));
    pulse_clear();

    // abort mid-frame
    send(SYNC, 2);
    send(32'h0100_0000, 2);
    send(32'h9999_9999, 0);
    pulse_clear();
    check("abort_busy", 64'(busy_o), 64'd0);
    check("abort_error", 64'(error_o), 64'd0);
    send(32'h8888_8888, 2);
    send(SYNC, 2);
    frame(2, 3, 32'h5A5A_5A5A, 32'hA5A5_A5A5);
    send(DESYNC, 2); done_exp++;

    // asynchronous reset mid-frame
    send(SYNC, 2);
    send(32'h0001_0000, 2);
    send(32'hDEAD_BEEF, 0);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_data", 64'(frame_data_o), 64'd0);
    check("arst_strobe", 64'(frame_strobe_o), 64'd0);
    check("arst_flags", {61'd0, busy_o, done_o, error_o}, 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    send(32'hFEED_FACE, 4);
    check("arst_idle", 64'(busy_o), 64'd0);
    send(SYNC, 2);
    frame(1, 1, 32'h1357_9BDF, 32'h2468_ACE0);
    send(DESYNC, 4); done_exp++;

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("done_total", 64'(done_cnt), 64'(done_exp));
    check("final_error", 64'(error_o), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fabric_frame_loader.md
FABRIC_FRAME_LOADER -- requirements
Module: fabric_frame_loader

Interface
REQ-001 Parameter NUM_COLUMNS, default 10: fabric columns addressable by FrameStrobe.
REQ-002 Parameter NUM_ROWS, default 12: 32-bit frame words per frame, one per fabric row.
REQ-003 Parameter FRAMES_PER_COLUMN, default 20: frames per column.
REQ-004 Parameter SYNC_WORD, default 32'hFAB0_FAB1: start-of-bitstream marker.
REQ-005 Parameter DESYNC_WORD, default 32'hDE5E_C0DE: end-of-bitstream marker.
REQ-006 clk_i  input  1  clock; all state changes on the rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 word_i  input  32  bitstream word from the SPI flash reader.
REQ-009 word_valid_i  input  1  single-cycle qualifier for word_i; there is no backpressure.
REQ-010 clear_i  input  1  synchronous abort: return to S_SYNC and clear error_o.
REQ-011 frame_data_o  output  32*NUM_ROWS  assembled frame data to the fabric.
REQ-012 frame_strobe_o  output  NUM_COLUMNS*FRAMES_PER_COLUMN  one-hot frame write strobe.
REQ-013 busy_o  output  1  high whenever state is not S_SYNC.
REQ-014 done_o  output  1  one-cycle pulse on accepted DESYNC_WORD.
REQ-015 error_o  output  1  sticky error flag.

Function
REQ-016 States: S_SYNC, S_ADDR, S_DATA, S_STROBE. Words are consumed only in cycles where word_valid_i=1.
REQ-017 S_SYNC:
  - word == SYNC_WORD -> S_ADDR.
  - any other word is discarded; no error.
REQ-018 S_ADDR, word == DESYNC_WORD:
  - pulse done_o for one cycle;
  - next state S_SYNC.
REQ-019 S_ADDR, any other word is an address word:
  - column = word[31:24], frame = word[23:16], word[15:0] ignored;
  - latch column and frame, clear row counter, next state S_DATA.
REQ-020 Address check: column >= NUM_COLUMNS or frame >= FRAMES_PER_COLUMN sets error_o. The frame is still consumed (NUM_ROWS data words), but no strobe is issued.
REQ-021 S_DATA:
  - the k-th data word (k = 0 .. NUM_ROWS-1) is written to frame_data_o[32*(NUM_ROWS-k)-1 -: 32], i.e. the first word lands in the top slice;
  - after word NUM_ROWS-1 -> S_STROBE.
REQ-022 S_STROBE:
  - lasts exactly one cycle;
  - frame_strobe_o bit (column*FRAMES_PER_COLUMN + frame) is high for that cycle only, unless the address was invalid;
  - next state S_ADDR.
REQ-023 frame_data_o is stable from the cycle after the last data word through the strobe cycle. It holds its value until the next frame's first data word.
REQ-024 frame_strobe_o is all-zero in every state except S_STROBE; at most one bit is ever high.
REQ-025 word_valid_i=1 during S_STROBE is an overrun: set error_o, drop the word, proceed to S_ADDR normally.
REQ-026 SYNC_WORD received in S_ADDR or S_DATA:
  - treated as ordinary address/data content;
  - no resynchronisation.
REQ-027 clear_i=1 in any state:
  - next state S_SYNC;
  - error_o cleared, row counter cleared;
  - frame_strobe_o and done_o forced 0 that cycle;
  - frame_data_o retained.
  - clear_i has priority over word_valid_i.
REQ-028 Row counter width is $clog2(NUM_ROWS+1); it never exceeds NUM_ROWS-1 in S_DATA.
REQ-029 error_o is set by REQ-020 or REQ-025 and clears only on clear_i or reset.

Reset
REQ-030 While rst_ni=0, outputs take these values immediately:
  - state S_SYNC;
  - frame_data_o=0, frame_strobe_o=0, busy_o=0, done_o=0, error_o=0;
  - latched column, frame and row counter = 0.
REQ-031 Reset asserted mid-frame abandons the frame; no strobe is issued and operation resumes in S_SYNC.

Verification
Bench parameters: NUM_COLUMNS=3, NUM_ROWS=2, FRAMES_PER_COLUMN=4.
REQ-032 Normal frame:
  - stimulus: SYNC, 32'h0102_0000, 32'hAAAA_AAAA, 32'h5555_5555, DESYNC (gaps >= 2 cycles);
  - response: frame_data_o=64'hAAAA_AAAA_5555_5555; frame_strobe_o bit 6 high for exactly one cycle; done_o pulses once; busy_o low afterward.
REQ-033 Pre-sync garbage:
  - stimulus: 32'h1234_5678, 32'h0, then a normal frame;
  - response: garbage ignored; error_o=0; correct strobe.
REQ-034 Invalid address:
  - stimulus: SYNC, 32'h0300_0000, two data words, then a valid frame to col 0 frame 3;
  - response: error_o=1; no strobe for the first frame; bit 3 strobes for the second.
REQ-035 Back-to-back words:
  - stimulus: word_valid_i held high, SYNC, addr 32'h0000_0000, D0, D1, next addr;
  - response: the next addr lands in S_STROBE, so error_o=1 and it is dropped; the bit 0 strobe still fires.
REQ-036 Abort:
  - stimulus: clear_i pulsed after the first data word, then a full new SYNC/frame;
  - response: no strobe for the aborted frame; error_o=0; busy_o=0 the cycle after clear; the new frame strobes correctly.
REQ-037 Reset mid-frame:
  - stimulus: rst_ni low asynchronously in S_DATA;
  - response: all outputs 0 immediately; no strobe after release until a new SYNC.
